// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   8N1 UART receiver followed by a first-word-fall-through receive FIFO.
//   The serial line is double-flopped. A small FSM then recovers each byte,
//   LSB first. A byte is pushed on the cycle its stop bit is sampled high.
//   Framing errors and dropped bytes are held in sticky flags until clr_err.
//
// Parameters
//   BAUD_DIV  clk cycles per serial bit (minimum 4)
//   DEPTH     FIFO entries (power of 2, minimum 2)
//   CNT_W     width of rx_count (2**CNT_W > DEPTH)
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   rx_i       asynchronous serial input, idle high
//   rd_en      pop the FIFO head (ignored when rx_valid=0)
//   rd_data    FIFO head byte, 0 when empty
//   rx_valid   FIFO not empty
//   rx_count   bytes held, 0..DEPTH
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: complete byte dropped because the FIFO was full
//   clr_err    clears frame_err and overrun
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int BAUD_DIV = 347,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_i,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             rx_valid,
  output logic [CNT_W-1:0] rx_count,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(DEPTH);

  localparam logic [BW-1:0]    CNT_HALF = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0]    CNT_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic [2:0]       r_state;
  logic [BW-1:0]    r_baud;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [7:0]       r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_frame_err;
  logic             r_overrun;

  logic w_rx_s;
  logic w_tick_half;
  logic w_tick_last;
  logic w_stop_smp;
  logic w_push;
  logic w_fe_set;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_accept;
  logic w_drop;

  // Stage p0/p1: two-flop synchronizer; presetting to 1 keeps a reset
  // from looking like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
    end else begin
      r_sync_p0 <= rx_i;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_rx_s      = r_sync_p1;
  assign w_tick_half = (r_baud == CNT_HALF);
  assign w_tick_last = (r_baud == CNT_LAST);
  assign w_stop_smp  = (r_state == ST_STOP) && w_tick_last;
  assign w_push      = w_stop_smp && w_rx_s;
  assign w_fe_set    = w_stop_smp && !w_rx_s;

  // Frame recovery FSM. The baud counter restarts at 0 on every state
  // entry and on every data-bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_baud <= '0;
          if (!w_rx_s) r_state <= ST_START;
        end
        ST_START: begin
          if (w_tick_half) begin
            r_baud  <= '0;
            r_bit   <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            r_state <= w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        ST_DATA: begin
          if (w_tick_last) begin
            r_baud <= '0;
            r_bit  <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= ST_STOP;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        ST_STOP: begin
          if (w_tick_last) begin
            r_baud  <= '0;
            r_state <= w_rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        ST_BREAK: begin
          // Wait out a held-low line so it yields one error, not a stream.
          r_baud <= '0;
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_baud  <= '0;
        end
      endcase
    end
  end

  // Data shift register, LSB arrives first so shift right into bit 7.
  always_ff @(posedge clk) begin
    if ((r_state == ST_DATA) && w_tick_last) r_shift <= {w_rx_s, r_shift[7:1]};
  end

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_FULL);
  assign w_pop    = rd_en && !w_empty;
  // A full FIFO still takes the byte if the head leaves in the same cycle.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  // Stage p2: FIFO storage and bookkeeping.
  always_ff @(posedge clk) begin
    if (w_accept && !rst) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + PW'(1);
      if (w_pop)    r_rptr <= r_rptr + PW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags: a new event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_fe_set)     r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;
      if (w_drop)       r_overrun   <= 1'b1;
      else if (clr_err) r_overrun   <= 1'b0;
    end
  end

  assign rd_data   = w_empty ? 8'h00 : r_mem[r_rptr];
  assign rx_valid  = !w_empty;
  assign rx_count  = r_count;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
